ddfs_iq_sweep: RTL and testbench

//  Parametrised successor of the 8-bit I/Q DDFS: phase accumulator plus quarter-wave sine LUT, giving signed sin/cos.

---
 rtl/ddfs_iq_sweep.sv | 230 +++++++++++++++++++++++
 tb/tb_ddfs_iq_sweep.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_iq_sweep.sv
// ddfs_iq_sweep: I/Q direct digital frequency synthesiser with config
// handshake, phase offset, phase-continuous retuning and linear chirp mode.
module ddfs_iq_sweep #(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    cfg_mode,
    input  logic [ACC_W-1:0]        cfg_ftw,
    input  logic [ACC_W-1:0]        cfg_step,
    input  logic [ACC_W-1:0]        cfg_stop,
    input  logic [ACC_W-1:0]        cfg_phase,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] q_sin,
    output logic signed [OUT_W-1:0] q_cos,
    output logic [LUT_AW+1:0]       q_phase,
    output logic                    sweep_done
);

    localparam int N   = 1 << LUT_AW;
    localparam int P   = LUT_AW + 2;
    localparam int MW  = OUT_W - 1;
    localparam int AMP = (1 << (OUT_W - 1)) - 1;

    // Fixed-point Q28 constants for the elaboration-time sine series
    localparam longint ONE     = 64'sd268435456;
    localparam longint HALF_PI = 64'sd421657428;

    typedef struct packed {
        logic             mode;
        logic [ACC_W-1:0] ftw;
        logic [ACC_W-1:0] step;
        logic [ACC_W-1:0] stop;
        logic [ACC_W-1:0] phase;
    } cfg_t;

    // round(AMP * sin(pi/2 * (k + 0.5) / N)) via Taylor series in Q28
    function automatic logic [MW-1:0] lut_val(input int k);
        longint x, x2, term, s, r;
        x    = (HALF_PI * longint'(2 * k + 1)) / longint'(2 * N);
        x2   = (x * x) / ONE;
        term = x;
        s    = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) / ONE) / longint'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        r = (s * longint'(AMP) + ONE / 2) / ONE;
        return r[MW-1:0];
    endfunction

    // Quadrants 1 and 3 read the quarter wave backwards (N-1-k == ~k)
    function automatic logic [LUT_AW-1:0] fold(input logic [P-1:0] i);
        return i[LUT_AW] ? ~i[LUT_AW-1:0] : i[LUT_AW-1:0];
    endfunction

    logic [MW-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic [MW-1:0] V = lut_val(g);
        assign rom[g] = V;
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    cfg_t             act_q, act_d;
    cfg_t             sh_q, sh_d;
    logic             run_q, run_d;
    logic             pend_q, pend_d;
    logic             rdy_q;
    logic             done_q, done_d;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W:0]   nxt_w;
    logic             apply_w;
    logic             samp_w;
    logic [P-1:0]     si_w;
    logic [P-1:0]     ci_w;

    assign samp_w = en && run_q;
    assign si_w   = P'((acc_q + act_q.phase) >> (ACC_W - P));
    assign ci_w   = {si_w[P-1:P-2] + 2'b01, si_w[LUT_AW-1:0]};

    // Next state: config apply, accumulation, sweep and handshake capture
    always_comb begin
        sum_w   = {1'b0, acc_q} + {1'b0, ftw_q};
        nxt_w   = {1'b0, ftw_q} + {1'b0, act_q.step};
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        act_d   = act_q;
        sh_d    = sh_q;
        run_d   = run_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        apply_w = 1'b0;
        if (pend_q && !run_q) begin
            apply_w = 1'b1;
            acc_d   = '0;
            run_d   = 1'b1;
        end else if (samp_w) begin
            acc_d = sum_w[ACC_W-1:0];
            if (pend_q && sum_w[ACC_W]) begin
                apply_w = 1'b1;
            end else if (act_q.mode) begin
                if (nxt_w > {1'b0, act_q.stop}) begin
                    ftw_d  = act_q.ftw;
                    done_d = 1'b1;
                end else begin
                    ftw_d = nxt_w[ACC_W-1:0];
                end
            end
        end
        if (apply_w) begin
            act_d  = sh_q;
            ftw_d  = sh_q.ftw;
            pend_d = 1'b0;
        end
        if (cfg_valid && rdy_q) begin
            sh_d   = '{mode: cfg_mode, ftw: cfg_ftw, step: cfg_step,
                       stop: cfg_stop, phase: cfg_phase};
            pend_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            ftw_q  <= '0;
            act_q  <= '0;
            sh_q   <= '0;
            run_q  <= 1'b0;
            pend_q <= 1'b0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ftw_q  <= ftw_d;
            act_q  <= act_d;
            sh_q   <= sh_d;
            run_q  <= run_d;
            pend_q <= pend_d;
            rdy_q  <= !pend_d;
            done_q <= done_d;
        end
    end

    logic              v1_q, sn1_q, cn1_q;
    logic [P-1:0]      ph1_q;
    logic [LUT_AW-1:0] sa1_q, ca1_q;

    // S1: capture phase index and folded LUT addresses on sampling edges
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            ph1_q <= '0;
            sa1_q <= '0;
            ca1_q <= '0;
            sn1_q <= 1'b0;
            cn1_q <= 1'b0;
        end else begin
            v1_q <= samp_w;
            if (samp_w) begin
                ph1_q <= si_w;
                sa1_q <= fold(si_w);
                ca1_q <= fold(ci_w);
                sn1_q <= si_w[P-1];
                cn1_q <= ci_w[P-1];
            end
        end
    end

    logic          v2_q, sn2_q, cn2_q;
    logic [P-1:0]  ph2_q;
    logic [MW-1:0] sm2_q, cm2_q;

    // S2: registered ROM read of both magnitudes
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q  <= 1'b0;
            ph2_q <= '0;
            sm2_q <= '0;
            cm2_q <= '0;
            sn2_q <= 1'b0;
            cn2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                ph2_q <= ph1_q;
                sm2_q <= rom[sa1_q];
                cm2_q <= rom[ca1_q];
                sn2_q <= sn1_q;
                cn2_q <= cn1_q;
            end
        end
    end

    logic             ov_q;
    logic [OUT_W-1:0] sin_q, cos_q;
    logic [P-1:0]     ph3_q;

    // S3: apply quadrant sign; outputs hold between samples
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q  <= 1'b0;
            sin_q <= '0;
            cos_q <= '0;
            ph3_q <= '0;
        end else begin
            ov_q <= v2_q;
            if (v2_q) begin
                sin_q <= sn2_q ? -{1'b0, sm2_q} : {1'b0, sm2_q};
                cos_q <= cn2_q ? -{1'b0, cm2_q} : {1'b0, cm2_q};
                ph3_q <= ph2_q;
            end
        end
    end

    assign cfg_ready  = rdy_q;
    assign out_valid  = ov_q;
    assign q_sin      = sin_q;
    assign q_cos      = cos_q;
    assign q_phase    = ph3_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_ddfs_iq_sweep.sv
// tb_ddfs_iq_sweep: directed stimulus with a sample scoreboard and
// hand-computed checkpoints for ddfs_iq_sweep.
module tb_ddfs_iq_sweep;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_mode = 1'b0;
    logic [23:0]       cfg_ftw = '0;
    logic [23:0]       cfg_step = '0;
    logic [23:0]       cfg_stop = '0;
    logic [23:0]       cfg_phase = '0;
    logic              cfg_ready;
    logic              out_valid;
    logic signed [7:0] q_sin;
    logic signed [7:0] q_cos;
    logic [9:0]        q_phase;
    logic              sweep_done;

    ddfs_iq_sweep #(.ACC_W(24), .LUT_AW(8), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_ftw(cfg_ftw), .cfg_step(cfg_step),
        .cfg_stop(cfg_stop), .cfg_phase(cfg_phase),
        .out_valid(out_valid), .q_sin(q_sin), .q_cos(q_cos),
        .q_phase(q_phase), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct { int ph; int s; int c; } smp_t;

    smp_t sbq[$];
    smp_t last_exp = '{0, 0, 0};
    smp_t mon_e;
    int   log_ph[$];
    int   log_s[$];
    int   log_c[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   first_cyc = -1;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;

    logic [23:0] m_acc = '0, m_ftw = '0, m_start = '0;
    logic [23:0] m_step = '0, m_stop = '0, m_poff = '0;
    logic        m_mode = 1'b0, m_run = 1'b0, m_pend = 1'b0;
    logic        m_rdy = 1'b0, m_done = 1'b0;
    logic [23:0] s_ftw = '0, s_step = '0, s_stop = '0, s_poff = '0;
    logic        s_mode = 1'b0;

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Expected sample from the ideal sinusoid at the phase-bin centre
    function automatic smp_t mk(logic [23:0] a);
        smp_t e;
        real  th;
        e.ph = int'(a[23:14]);
        th   = 2.0 * 3.14159265358979323846 * (real'(e.ph) + 0.5) / 1024.0;
        e.s  = rnd(127.0 * $sin(th));
        e.c  = rnd(127.0 * $cos(th));
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic m_load();
        m_ftw   = s_ftw;
        m_start = s_ftw;
        m_step  = s_step;
        m_stop  = s_stop;
        m_poff  = s_poff;
        m_mode  = s_mode;
        m_pend  = 1'b0;
    endtask

    // One clock edge: advance the reference model, then check control outputs
    task automatic tick();
        bit          acpt;
        logic [24:0] sum;
        logic [24:0] nxt;
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_acc = '0; m_ftw = '0; m_start = '0; m_step = '0;
            m_stop = '0; m_poff = '0; m_mode = 1'b0;
            m_run = 1'b0; m_pend = 1'b0; m_rdy = 1'b0;
            sbq.delete();
            log_ph.delete(); log_s.delete(); log_c.delete();
            last_exp  = '{0, 0, 0};
            first_cyc = -1;
        end else begin
            acpt = cfg_valid && m_rdy;
            if (en && m_run) sbq.push_back(mk(m_acc + m_poff));
            if (m_pend && !m_run) begin
                m_acc = '0;
                m_run = 1'b1;
                m_load();
            end else if (en && m_run) begin
                sum   = {1'b0, m_acc} + {1'b0, m_ftw};
                m_acc = sum[23:0];
                if (m_pend && sum[24]) begin
                    m_load();
                end else if (m_mode) begin
                    nxt = {1'b0, m_ftw} + {1'b0, m_step};
                    if (nxt > {1'b0, m_stop}) begin
                        m_ftw  = m_start;
                        m_done = 1'b1;
                    end else begin
                        m_ftw = nxt[23:0];
                    end
                end
            end
            if (acpt) begin
                s_mode = cfg_mode; s_ftw = cfg_ftw; s_step = cfg_step;
                s_stop = cfg_stop; s_poff = cfg_phase;
                m_pend  = 1'b1;
                acc_cyc = cyc;
            end
            m_rdy = !m_pend;
        end
        #1;
        chk("cfg_ready", int'(cfg_ready), int'(m_rdy));
        chk("sweep_done", int'(sweep_done), int'(m_done));
        if (sweep_done) done_cnt++;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic send_cfg(logic md, logic [23:0] f, logic [23:0] st,
                            logic [23:0] sp, logic [23:0] ph);
        cfg_valid = 1'b1;
        cfg_mode  = md;
        cfg_ftw   = f;
        cfg_step  = st;
        cfg_stop  = sp;
        cfg_phase = ph;
        acc_cyc   = -1;
        for (int i = 0; i < 3000 && acc_cyc < 0; i++) tick();
        if (acc_cyc < 0) chk("cfg_accept_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        en = 1'b0;
        run(5);
        chk("drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        tick();
    endtask

    // Monitor: pop and compare each sample; outputs must hold otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (out_valid) begin
                log_ph.push_back(int'(q_phase));
                log_s.push_back(int'(q_sin));
                log_c.push_back(int'(q_cos));
                if (first_cyc < 0) first_cyc = cyc;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample got ph=%0d", q_phase);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.ph != int'(q_phase) || mon_e.s != int'(q_sin) ||
                        mon_e.c != int'(q_cos)) begin
                        errors++;
                        $display("FAIL sample got ph=%0d sin=%0d cos=%0d want ph=%0d sin=%0d cos=%0d",
                                 q_phase, q_sin, q_cos, mon_e.ph, mon_e.s, mon_e.c);
                    end
                    last_exp = mon_e;
                end
            end else if (last_exp.ph != int'(q_phase) ||
                         last_exp.s != int'(q_sin) ||
                         last_exp.c != int'(q_cos)) begin
                errors++;
                $display("FAIL hold got ph=%0d sin=%0d cos=%0d want ph=%0d sin=%0d cos=%0d",
                         q_phase, q_sin, q_cos, last_exp.ph, last_exp.s, last_exp.c);
            end
        end
    end

    initial begin
        int a;
        int idx;

        // T1: reset state and release
        reset = 1'b1;
        run(5);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sin", int'(q_sin), 0);
        chk("rst_cos", int'(q_cos), 0);
        chk("rst_phase", int'(q_phase), 0);
        chk("rst_done", int'(sweep_done), 0);
        chk("rst_ready", int'(cfg_ready), 0);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick();
        chk("rel_ready", int'(cfg_ready), 1);
        chk("rel_valid", int'(out_valid), 0);

        // T2: fixed tone, ftw = 2^16
        en = 1'b1;
        send_cfg(1'b0, 24'h010000, 24'h0, 24'h0, 24'h0);
        a = acc_cyc;
        run(300);
        chk("t2_latency", first_cyc - a, 4);
        chk("t2_count", int'(log_ph.size() >= 65), 1);
        chk("t2_first_ph", log_ph[0], 0);
        chk("t2_first_sin", log_s[0], 0);
        chk("t2_first_cos", log_c[0], 127);
        chk("t2_second_ph", log_ph[1], 4);
        chk("t2_q1_ph", log_ph[64], 256);
        chk("t2_q1_sin", log_s[64], 127);
        chk("t2_q1_cos", log_c[64], 0);
        drain();

        // T3: phase offsets of a quarter and a half turn
        do_reset();
        en = 1'b1;
        send_cfg(1'b0, 24'h010000, 24'h0, 24'h0, 24'h400000);
        run(10);
        chk("t3a_ph", log_ph[0], 256);
        chk("t3a_sin", log_s[0], 127);
        chk("t3a_cos", log_c[0], 0);
        drain();
        do_reset();
        en = 1'b1;
        send_cfg(1'b0, 24'h010000, 24'h0, 24'h0, 24'h800000);
        run(10);
        chk("t3b_ph", log_ph[0], 512);
        chk("t3b_sin", log_s[0], 0);
        chk("t3b_cos", log_c[0], -127);
        drain();

        // T4: retune mid-period waits for the accumulator wrap
        do_reset();
        en = 1'b1;
        send_cfg(1'b0, 24'h010000, 24'h0, 24'h0, 24'h0);
        run(100);
        send_cfg(1'b0, 24'h020000, 24'h0, 24'h0, 24'h0);
        run(50);
        chk("t4_pending", int'(cfg_ready), 0);
        run(200);
        chk("t4_applied", int'(cfg_ready), 1);
        idx = -1;
        for (int i = 0; i + 2 < log_ph.size(); i++) begin
            if (idx < 0 && log_ph[i] == 1020) idx = i;
        end
        chk("t4_found", int'(idx >= 0), 1);
        if (idx >= 0) begin
            chk("t4_wrap0", log_ph[idx+1], 0);
            chk("t4_wrap8", log_ph[idx+2], 8);
        end
        drain();

        // T5: linear sweep 1..4 x 2^16 with restart pulses
        do_reset();
        en = 1'b1;
        send_cfg(1'b1, 24'h010000, 24'h010000, 24'h040000, 24'h0);
        done_cnt = 0;
        run(41);
        chk("t5_pulses", done_cnt, 10);
        chk("t5_ph0", log_ph[0], 0);
        chk("t5_ph1", log_ph[1], 4);
        chk("t5_ph2", log_ph[2], 12);
        chk("t5_ph3", log_ph[3], 24);
        chk("t5_ph4", log_ph[4], 40);
        chk("t5_ph5", log_ph[5], 44);
        drain();

        // T6: en toggling, then reset with samples in flight
        do_reset();
        en = 1'b0;
        send_cfg(1'b0, 24'h010000, 24'h0, 24'h0, 24'h0);
        for (int i = 0; i < 40; i++) begin
            en = i[0];
            tick();
        end
        drain();
        chk("t6_count", log_ph.size(), 20);
        chk("t6_last_ph", log_ph[19], 76);
        en = 1'b1;
        run(2);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(10);
        chk("t6_no_valid", log_ph.size(), 0);
        chk("t6_ready", int'(cfg_ready), 1);
        chk("t6_sin", int'(q_sin), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
